// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to binary converter (reverse double-dabble).
// One bit of the binary result is produced per SHIFT; ADJ re-normalises the BCD digits.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  data_en,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  valid_bin,
    output logic                  bcd_err,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam logic [3:0] CNT_LAST = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADJ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [BCD_W-1:0]   bcd_r, bcd_s;
    logic [BIN_W-1:0]   bin_r, bin_s;
    logic [3:0]         cnt_r, cnt_s;
    logic               err_r, err_s;
    logic [BIN_W-1:0]   bin_out_s;
    logic               valid_s;
    logic               bcd_err_s;

    function automatic logic digits_valid(input logic [BCD_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ok = ok & (v[4*i +: 4] <= 4'd9);
        end
        return ok;
    endfunction

    // A digit >= 8 after a right shift carries a half-ten from above; subtracting 3 restores BCD.
    function automatic logic [BCD_W-1:0] digits_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d >= 4'd8) ? (d - 4'd3) : d;
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (data_en) begin
                    state_s = digits_valid(bcd_in) ? SHIFT : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = ADJ;
                end
            end
            ADJ:     state_s = SHIFT;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        bcd_s     = bcd_r;
        bin_s     = bin_r;
        cnt_s     = cnt_r;
        err_s     = err_r;
        bin_out_s = bin_out;
        bcd_err_s = bcd_err;
        valid_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (data_en && digits_valid(bcd_in)) begin
                    bcd_s = bcd_in;
                    bin_s = '0;
                    cnt_s = 4'd0;
                    err_s = 1'b0;
                end else if (data_en) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            SHIFT: begin
                {bcd_s, bin_s} = {1'b0, bcd_r, bin_r[BIN_W-1:1]};
                cnt_s = cnt_r + 4'd1;
            end
            ADJ: begin
                bcd_s = digits_adjust(bcd_r);
            end
            DONE: begin
                valid_s   = 1'b1;
                bin_out_s = err_r ? '0 : bin_r;
                bcd_err_s = err_r;
                err_s     = 1'b0;
                cnt_s     = 4'd0;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt_r     <= 4'd0;
            err_r     <= 1'b0;
            bin_out   <= '0;
            valid_bin <= 1'b0;
            bcd_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_r     <= bcd_s;
            bin_r     <= bin_s;
            cnt_r     <= cnt_s;
            err_r     <= err_s;
            bin_out   <= bin_out_s;
            valid_bin <= valid_s;
            bcd_err   <= bcd_err_s;
            busy      <= (state_s != IDLE);
        end
    end

endmodule
